// File: rtl/fadd_pkg.sv
// Shared types and clamp constants for the fixed-point accumulate controller.
package fadd_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {ACC_IDLE, ACC_ACCUM, ACC_DONE} acc_state_t;

    // Largest positive two's-complement value of a w-bit word, zero-extended to MAX_W.
    function automatic logic [MAX_W-1:0] sat_max(input int w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    // Most negative w-bit value (only the sign bit set), zero-extended to MAX_W.
    function automatic logic [MAX_W-1:0] sat_min(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/fadd_accum_ctrl_if.sv
// Term-in / sum-out handshake bundle for fadd_accum_ctrl.
interface fadd_accum_ctrl_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] term;
    logic             term_valid;
    logic             term_ready;
    logic [WIDTH-1:0] sum;
    logic             sum_valid;
    logic             sum_ready;
    logic             ovf;
    logic             busy;

    modport master (output term, term_valid, sum_ready,
                    input  term_ready, sum, sum_valid, ovf, busy);
    modport slave  (input  term, term_valid, sum_ready,
                    output term_ready, sum, sum_valid, ovf, busy);
endinterface

// File: rtl/fadd.sv
// Wrapping two's-complement Q-format adder with signed-overflow flag.
module fadd #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovr
);
    // Both operands share the same binary point, so FRAC only has to be legal.
    if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
        $error("fadd: FRAC must lie in 0..WIDTH-1");
    end

    assign o_sum = i_a + i_b;
    assign o_ovr = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);
endmodule

// File: rtl/fadd_accum_ctrl.sv
// Accumulates TAPS terms per frame through one shared fadd and presents the sum.
// Optional macro FADD_ACCUM_SAT_EN: clamp the accumulator on adder overflow.
module fadd_accum_ctrl
    import fadd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12,
    parameter int TAPS  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    fadd_accum_ctrl_if.slave  bus
);
    localparam int CW = $clog2(TAPS + 1);
    localparam logic [CW-1:0] LAST = CW'(TAPS - 1);

    if (TAPS < 2 || TAPS > 256) begin : g_bad_taps
        $error("fadd_accum_ctrl: TAPS must lie in 2..256");
    end

    acc_state_t       state;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             ovf_sticky;
    logic [WIDTH-1:0] add_sum;
    logic             add_ovr;
    logic [WIDTH-1:0] acc_nxt;
    logic             accept;

    fadd #(.WIDTH(WIDTH), .FRAC(FRAC)) u_fadd (
        .i_a   (acc),
        .i_b   (bus.term),
        .o_sum (add_sum),
        .o_ovr (add_ovr)
    );

`ifdef FADD_ACCUM_SAT_EN
    localparam logic [MAX_W-1:0] SAT_MAX_W = sat_max(WIDTH);
    localparam logic [MAX_W-1:0] SAT_MIN_W = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MAX   = SAT_MAX_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MIN   = SAT_MIN_W[WIDTH-1:0];
    // Overflow only happens with like-signed operands, so acc's sign picks the rail.
    assign acc_nxt = !add_ovr ? add_sum : (acc[WIDTH-1] ? SAT_MIN : SAT_MAX);
`else
    assign acc_nxt = add_sum;
`endif

    // Held low through reset so nothing is taken while the block is being cleared.
    assign bus.term_ready = i_rst_n && (state != ACC_DONE);
    assign accept         = bus.term_valid && bus.term_ready;
    assign bus.sum        = acc;
    assign bus.sum_valid  = (state == ACC_DONE);
    assign bus.ovf        = ovf_sticky;
    assign bus.busy       = (state == ACC_ACCUM);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= ACC_IDLE;
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            case (state)
                ACC_IDLE: if (accept) begin
                    acc        <= bus.term;
                    cnt        <= CW'(1);
                    ovf_sticky <= 1'b0;
                    state      <= ACC_ACCUM;
                end
                ACC_ACCUM: if (accept) begin
                    acc        <= acc_nxt;
                    cnt        <= cnt + 1'b1;
                    ovf_sticky <= ovf_sticky | add_ovr;
                    if (cnt == LAST) state <= ACC_DONE;
                end
                ACC_DONE: if (bus.sum_ready) begin
                    acc        <= '0;
                    cnt        <= '0;
                    ovf_sticky <= 1'b0;
                    state      <= ACC_IDLE;
                end
                default: state <= ACC_IDLE;
            endcase
        end
    end
endmodule
